// File: rtl/grid_mover_if.sv
// Player-motion handshake between the game top level (master) and grid_mover (slave).
// Carries step requests in and position/outcome status back out.
interface grid_mover_if #(
    parameter int POS_W = 9
);
    logic             step;
    logic [1:0]       dir_in;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic [1:0]       dir;
    logic             busy;
    logic             done;
    logic             blocked;
    logic             moving;

    modport master (
        output step, dir_in,
        input  pos_x, pos_y, dir, busy, done, blocked, moving
    );

    modport slave (
        input  step, dir_in,
        output pos_x, pos_y, dir, busy, done, blocked, moving
    );
endinterface

// File: rtl/grid_mover.sv
// Pixel-stepping player motion on a walled cell grid; turns only at cell alignment.
// Optional macro GRID_MOVER_REVERSE_EN allows an immediate U-turn while between cells.
module grid_mover #(
    parameter int GRID_W    = 10,
    parameter int GRID_H    = 15,
    parameter int CELL_LOG2 = 5,
    parameter int POS_W     = 9,
    parameter int START_X   = 0,
    parameter int START_Y   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [(GRID_H+1)*GRID_W-1:0]  h_walls,
    input  logic [GRID_H*(GRID_W+1)-1:0]  v_walls,
    grid_mover_if.slave                   bus
);

    // state  | meaning
    // IDLE   | waiting for a step request
    // LOOKUP | sampling the wall edge and bounds for the latched direction
    // DECIDE | refuse (done+blocked) or commit the pixel move
    // MOVE   | position already updated, done pulse is showing
    typedef enum logic [1:0] {IDLE, LOOKUP, DECIDE, MOVE} state_t;

    localparam int CW  = POS_W - CELL_LOG2;
    localparam int HN  = (GRID_H + 1) * GRID_W;
    localparam int VN  = GRID_H * (GRID_W + 1);
    localparam int HIW = $clog2(HN);
    localparam int VIW = $clog2(VN);
    localparam logic [POS_W-1:0] RST_X = POS_W'(START_X << CELL_LOG2);
    localparam logic [POS_W-1:0] RST_Y = POS_W'(START_Y << CELL_LOG2);

    state_t           state, state_n;
    logic [POS_W-1:0] pos_x, pos_y, pos_x_n, pos_y_n;
    logic [1:0]       dir_r, dir_n, move_dir;
    logic             wall_hit, wall_hit_n, oob, oob_n;
    logic             done_r, done_n, blocked_r, blocked_n, moving_r, moving_n;
    logic             do_move, aligned, rev;
    logic [CW-1:0]    cx, cy;
    logic [HIW-1:0]   h_idx;
    logic [VIW-1:0]   v_idx;

    assign cx      = pos_x[POS_W-1:CELL_LOG2];
    assign cy      = pos_y[POS_W-1:CELL_LOG2];
    assign aligned = (pos_x[CELL_LOG2-1:0] == '0) && (pos_y[CELL_LOG2-1:0] == '0);

`ifdef GRID_MOVER_REVERSE_EN
    assign rev = (bus.dir_in == (dir_r ^ 2'd2));
`else
    assign rev = 1'b0;
`endif

    // The position register is written on the edge that enters MOVE, so the
    // new pixel and the done pulse appear together in the MOVE cycle.
    always_comb begin
        state_n    = state;
        pos_x_n    = pos_x;
        pos_y_n    = pos_y;
        dir_n      = dir_r;
        wall_hit_n = wall_hit;
        oob_n      = oob;
        done_n     = 1'b0;
        blocked_n  = 1'b0;
        moving_n   = moving_r;
        do_move    = 1'b0;
        move_dir   = dir_r;
        h_idx      = '0;
        v_idx      = '0;

        case (state)
            IDLE: begin
                if (bus.step) begin
                    if (aligned) begin
                        dir_n   = bus.dir_in;
                        state_n = LOOKUP;
                    end else begin
                        if (rev) begin
                            dir_n    = bus.dir_in;
                            move_dir = bus.dir_in;
                        end
                        do_move  = 1'b1;
                        done_n   = 1'b1;
                        moving_n = 1'b1;
                        state_n  = MOVE;
                    end
                end
            end
            LOOKUP: begin
                case (dir_r)
                    2'd0: begin
                        v_idx      = VIW'(int'(cy) * (GRID_W + 1) + int'(cx) + 1);
                        wall_hit_n = v_walls[v_idx];
                        oob_n      = (cx == CW'(GRID_W - 1));
                    end
                    2'd1: begin
                        h_idx      = HIW'((int'(cy) + 1) * GRID_W + int'(cx));
                        wall_hit_n = h_walls[h_idx];
                        oob_n      = (cy == CW'(GRID_H - 1));
                    end
                    2'd2: begin
                        v_idx      = VIW'(int'(cy) * (GRID_W + 1) + int'(cx));
                        wall_hit_n = v_walls[v_idx];
                        oob_n      = (cx == '0);
                    end
                    default: begin
                        h_idx      = HIW'(int'(cy) * GRID_W + int'(cx));
                        wall_hit_n = h_walls[h_idx];
                        oob_n      = (cy == '0);
                    end
                endcase
                state_n = DECIDE;
            end
            DECIDE: begin
                done_n = 1'b1;
                if (wall_hit || oob) begin
                    blocked_n = 1'b1;
                    moving_n  = 1'b0;
                    state_n   = IDLE;
                end else begin
                    do_move  = 1'b1;
                    moving_n = 1'b1;
                    state_n  = MOVE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (do_move) begin
            case (move_dir)
                2'd0:    pos_x_n = pos_x + POS_W'(1);
                2'd1:    pos_y_n = pos_y + POS_W'(1);
                2'd2:    pos_x_n = pos_x - POS_W'(1);
                default: pos_y_n = pos_y - POS_W'(1);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pos_x     <= RST_X;
            pos_y     <= RST_Y;
            dir_r     <= 2'd0;
            wall_hit  <= 1'b0;
            oob       <= 1'b0;
            done_r    <= 1'b0;
            blocked_r <= 1'b0;
            moving_r  <= 1'b0;
        end else begin
            state     <= state_n;
            pos_x     <= pos_x_n;
            pos_y     <= pos_y_n;
            dir_r     <= dir_n;
            wall_hit  <= wall_hit_n;
            oob       <= oob_n;
            done_r    <= done_n;
            blocked_r <= blocked_n;
            moving_r  <= moving_n;
        end
    end

    assign bus.pos_x   = pos_x;
    assign bus.pos_y   = pos_y;
    assign bus.dir     = dir_r;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_r;
    assign bus.blocked = blocked_r;
    assign bus.moving  = moving_r;

endmodule

// File: tb/tb_grid_mover.sv
// Scoreboard bench for grid_mover: steps push expected outcomes, a monitor
// pops and compares them on every done pulse.
module tb_grid_mover;

    localparam int GW = 10;
    localparam int GH = 15;

    typedef struct {
        int       issue;
        int       lat;
        int       px;
        int       py;
        int       d;
        int       blk;
        int       mov;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [(GH+1)*GW-1:0] h_walls;
    logic [GH*(GW+1)-1:0] v_walls;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    grid_mover_if #(.POS_W(9)) bus ();
    grid_mover_if #(.POS_W(9)) bus_a ();

    grid_mover #(.GRID_W(GW), .GRID_H(GH), .CELL_LOG2(5), .POS_W(9),
                 .START_X(0), .START_Y(0)) dut (
        .clk(clk), .rst(rst), .h_walls(h_walls), .v_walls(v_walls), .bus(bus)
    );

    grid_mover #(.GRID_W(GW), .GRID_H(GH), .CELL_LOG2(5), .POS_W(9),
                 .START_X(2), .START_Y(3)) dut_a (
        .clk(clk), .rst(rst), .h_walls(h_walls), .v_walls(v_walls), .bus(bus_a)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("latency", cyc - e.issue, e.lat);
                chk("pos_x",   int'(bus.pos_x), e.px);
                chk("pos_y",   int'(bus.pos_y), e.py);
                chk("dir",     int'(bus.dir), e.d);
                chk("blocked", int'(bus.blocked), e.blk);
                chk("moving",  int'(bus.moving), e.mov);
            end
        end
        if (!rst && bus.blocked && !bus.done)
            chk("blocked_without_done", 1, 0);
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy || q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 60) begin
                chk("idle_timeout", n, 60);
                q.delete();
                break;
            end
        end
    endtask

    task automatic issue(input logic [1:0] d, input int lat, input int px,
                         input int py, input int dd, input int blk, input int mov);
        exp_t e;
        e.issue = cyc;
        e.lat = lat; e.px = px; e.py = py; e.d = dd; e.blk = blk; e.mov = mov;
        q.push_back(e);
        bus.step = 1'b1;
        bus.dir_in = d;
        @(negedge clk);
        bus.step = 1'b0;
        wait_idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        h_walls = '0;
        v_walls = '0;
        bus.step = 1'b0;
        bus.dir_in = 2'd0;
        bus_a.step = 1'b0;
        bus_a.dir_in = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_pos_x",  int'(bus_a.pos_x), 64);
        chk("rst_a_pos_y",  int'(bus_a.pos_y), 96);
        chk("rst_a_dir",    int'(bus_a.dir), 0);
        chk("rst_a_busy",   int'(bus_a.busy), 0);
        chk("rst_a_done",   int'(bus_a.done), 0);
        chk("rst_a_moving", int'(bus_a.moving), 0);
        chk("rst_pos_x",    int'(bus.pos_x), 0);
        chk("rst_pos_y",    int'(bus.pos_y), 0);
        chk("rst_blocked",  int'(bus.blocked), 0);
        rst = 1'b0;
        @(negedge clk);

        // reset mid-step: no done may follow
        bus.step = 1'b1;
        bus.dir_in = 2'd0;
        @(negedge clk);
        bus.step = 1'b0;
        chk("midstep_busy", int'(bus.busy), 1);
        do_reset();
        repeat (5) @(negedge clk);
        chk("abort_pos_x", int'(bus.pos_x), 0);
        chk("abort_busy",  int'(bus.busy), 0);

        // grid bounds at the top-left corner
        issue(2'd2, 3, 0, 0, 2, 1, 0);
        issue(2'd3, 3, 0, 0, 3, 1, 0);

        // walls: right edge of cell (0,0) closed, then down blocked/open
        v_walls[1] = 1'b1;
        issue(2'd0, 3, 0, 0, 0, 1, 0);
        h_walls[10] = 1'b1;
        issue(2'd1, 3, 0, 0, 1, 1, 0);
        h_walls[10] = 1'b0;
        issue(2'd1, 3, 0, 1, 1, 0, 1);
        v_walls[1] = 1'b0;

        // open grid: 32 right steps from (0,0)
        do_reset();
        for (int i = 0; i < 32; i++)
            issue(2'd0, (i == 0) ? 3 : 1, i + 1, 0, 0, 0, 1);
        chk("run_end_pos_x",  int'(bus.pos_x), 32);
        chk("run_end_moving", int'(bus.moving), 1);

        // step while busy is dropped
        do_reset();
        begin
            exp_t e;
            e.issue = cyc; e.lat = 3; e.px = 1; e.py = 0; e.d = 0; e.blk = 0; e.mov = 1;
            q.push_back(e);
            bus.step = 1'b1;
            bus.dir_in = 2'd0;
            @(negedge clk);
            @(negedge clk);
            bus.step = 1'b0;
            wait_idle();
            repeat (4) @(negedge clk);
            chk("drop_pos_x", int'(bus.pos_x), 1);
        end

        // walk to pos_x=5, then request the opposite direction
        for (int i = 2; i <= 5; i++)
            issue(2'd0, 1, i, 0, 0, 0, 1);
`ifdef GRID_MOVER_REVERSE_EN
        issue(2'd2, 1, 4, 0, 2, 0, 1);
`else
        issue(2'd2, 1, 6, 0, 0, 0, 1);
`endif
        // perpendicular request while unaligned is always ignored
        issue(2'd1, 1,
`ifdef GRID_MOVER_REVERSE_EN
              3, 0, 2,
`else
              7, 0, 0,
`endif
              0, 1);

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
